// File: rtl/inta_sequencer.sv
// inta_sequencer: interrupt acknowledge sequencer in the style of the 8259.
// It picks the highest-priority pending, unmasked request that outranks
// everything already in service, raises int_out, and runs the two-pulse
// INTA handshake. The first pulse latches the winning IR into isr and, on
// a cascaded master, drives the slave ID onto the cascade bus. The second
// pulse places the vector byte on the data bus.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   irr, imr          request levels and mask (1 = masked)
//   SNGL, SP          single mode / master(1) or slave(0) when cascaded
//   slaveReg          own slave ID (slave mode)
//   slave_map         master: IR lines that have a slave attached
//   vec_base          vector bits T7..T3
//   aeoi, eoi         automatic EOI enable, non-specific EOI strobe
//   inta_n            active-low acknowledge, synchronous to clk
//   casc_in           cascade bus as seen by a slave
//   int_out           interrupt request to CPU / master
//   casc_out, casc_oe cascade ID and its drive enable
//   isr               in-service register
//   data_out, data_oe vector byte and its drive enable
module inta_sequencer #(
  parameter int INTA_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       SNGL,
  input  logic       SP,
  input  logic [2:0] slaveReg,
  input  logic [7:0] slave_map,
  input  logic [4:0] vec_base,
  input  logic       aeoi,
  input  logic       eoi,
  input  logic       inta_n,
  input  logic [2:0] casc_in,
  output logic       int_out,
  output logic [2:0] casc_out,
  output logic       casc_oe,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {IDLE, WAIT1, ACK1, WAIT2, ACK2} state_t;

  state_t     state;
  logic       inta_p1;   // previous inta_n sample
  logic       match;     // slave: cascade bus addressed us on first INTA
  logic [7:0] cnt;
  logic [2:0] id;

  // Index of the lowest set bit, or 8 when the vector is empty.
  function automatic logic [3:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  logic [7:0] pend;
  logic [3:0] win;
  logic [3:0] isr_lo;
  logic       pend_any;
  logic       eligible;
  logic       fall;
  logic       rise;
  logic [2:0] ack_id;
  logic       vec_ok;
  logic [7:0] isr_nxt;

  assign pend     = irr & ~imr;
  assign win      = lowest_idx(pend);
  assign isr_lo   = lowest_idx(isr);
  assign pend_any = (pend != 8'd0);
  // An empty isr gives isr_lo = 8, so any pending request outranks it.
  assign eligible = pend_any && (win < isr_lo);
  assign fall     = !inta_n && inta_p1;
  assign rise     = inta_n && !inta_p1;
  // No request left at the first INTA: answer with the IR7 vector.
  assign ack_id   = pend_any ? win[2:0] : 3'd7;
  assign vec_ok   = SNGL || (SP && !slave_map[id]) || (!SP && match);

  // EOI works on the isr as it stood before this cycle's set, so a
  // same-cycle acknowledge keeps its new bit.
  always_comb begin
    isr_nxt = isr;
    if (eoi && !isr_lo[3]) isr_nxt = isr_nxt & ~(8'b1 << isr_lo[2:0]);
    if (state == WAIT1 && fall && pend_any) isr_nxt = isr_nxt | (8'b1 << win[2:0]);
    if (state == ACK2 && rise && aeoi) isr_nxt = isr_nxt & ~(8'b1 << id);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inta_p1  <= 1'b1;
      match    <= 1'b0;
      cnt      <= 8'd0;
      id       <= 3'd0;
      isr      <= 8'd0;
      int_out  <= 1'b0;
      casc_out <= 3'd0;
      casc_oe  <= 1'b0;
      data_out <= 8'd0;
      data_oe  <= 1'b0;
    end else begin
      inta_p1 <= inta_n;
      isr     <= isr_nxt;
      case (state)
        IDLE: begin
          if (eligible) begin
            state   <= WAIT1;
            int_out <= 1'b1;
          end
        end
        // int_out stays up even if the request goes away; the CPU is
        // already committed to acknowledging.
        WAIT1: begin
          if (fall) begin
            state   <= ACK1;
            int_out <= 1'b0;
            id      <= ack_id;
            match   <= (casc_in == slaveReg);
            if (!SNGL && SP && slave_map[ack_id]) begin
              casc_out <= ack_id;
              casc_oe  <= 1'b1;
            end
          end
        end
        ACK1: begin
          if (rise) begin
            state <= WAIT2;
            cnt   <= 8'd0;
          end
        end
        // A missing second INTA abandons the sequence but leaves isr set.
        WAIT2: begin
          if (fall) begin
            state    <= ACK2;
            data_out <= {vec_base, id};
            data_oe  <= vec_ok;
          end else if (cnt == 8'(INTA_TIMEOUT - 1)) begin
            state   <= IDLE;
            casc_oe <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK2: begin
          if (rise) begin
            state   <= IDLE;
            data_oe <= 1'b0;
            casc_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irr, imr, slave_map;
  logic       SNGL, SP, aeoi, eoi, inta_n;
  logic [2:0] slaveReg, casc_in;
  logic [4:0] vec_base;
  logic       int_out, casc_oe, data_oe;
  logic [2:0] casc_out;
  logic [7:0] isr, data_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inta_sequencer #(.INTA_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .irr(irr), .imr(imr), .SNGL(SNGL), .SP(SP),
    .slaveReg(slaveReg), .slave_map(slave_map), .vec_base(vec_base),
    .aeoi(aeoi), .eoi(eoi), .inta_n(inta_n), .casc_in(casc_in),
    .int_out(int_out), .casc_out(casc_out), .casc_oe(casc_oe), .isr(isr),
    .data_out(data_out), .data_oe(data_oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irr = 8'd0; imr = 8'd0; SNGL = 1'b1; SP = 1'b1; slaveReg = 3'd0;
    slave_map = 8'd0; vec_base = 5'd0; aeoi = 1'b0; eoi = 1'b0;
    inta_n = 1'b1; casc_in = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Full acknowledge for request r in the current mode; stimulus only.
  task automatic run_seq(input logic [7:0] r);
    irr = r; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; irr = 8'd0; tick();
  endtask

  // Priority index of the lowest set bit, 8 if none.
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({int_out, casc_oe, data_oe, casc_out, isr, data_out} !== 22'd0) begin
      errors++; $display("FAIL reset_initial: got %h want 0", {int_out, casc_oe, data_oe, casc_out, isr, data_out});
    end
    SNGL = 1'b0; SP = 1'b1; slave_map = 8'h01; irr = 8'h01; tick();
    inta_n = 1'b0; tick();
    rst = 1'b1; inta_n = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if ({int_out, casc_oe, data_oe, casc_out, isr, data_out} !== 22'd0) begin
      errors++; $display("FAIL reset_midseq: got %h want 0", {int_out, casc_oe, data_oe, casc_out, isr, data_out});
    end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    vec_base = 5'h08; irr = 8'h24; tick();
    checks++;
    if (int_out !== 1'b1) begin errors++; $display("FAIL single_int: got %b want 1", int_out); end
    inta_n = 1'b0; tick();
    checks++;
    if (isr !== 8'h04) begin errors++; $display("FAIL single_isr: got %h want 04", isr); end
    checks++;
    if (int_out !== 1'b0) begin errors++; $display("FAIL single_int_drop: got %b want 0", int_out); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++;
    if (data_out !== 8'h42 || data_oe !== 1'b1) begin
      errors++; $display("FAIL single_vec: got %h/%b want 42/1", data_out, data_oe);
    end
    tick();
    checks++;
    if (data_oe !== 1'b1) begin errors++; $display("FAIL single_vec_hold: got %b want 1", data_oe); end
    inta_n = 1'b1; irr = 8'd0; tick();
    checks++;
    if (data_oe !== 1'b0 || isr !== 8'h04) begin
      errors++; $display("FAIL single_end: got oe=%b isr=%h want 0/04", data_oe, isr);
    end
  endtask

  task automatic test_master();
    do_reset();
    SNGL = 1'b0; SP = 1'b1; slave_map = 8'h08; irr = 8'h08; tick();
    inta_n = 1'b0; tick();
    checks++;
    if (casc_out !== 3'd3 || casc_oe !== 1'b1) begin
      errors++; $display("FAIL master_casc: got %0d/%b want 3/1", casc_out, casc_oe);
    end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++;
    if (casc_oe !== 1'b1 || data_oe !== 1'b0) begin
      errors++; $display("FAIL master_ack2: got casc_oe=%b data_oe=%b want 1/0", casc_oe, data_oe);
    end
    inta_n = 1'b1; irr = 8'd0; tick();
    checks++;
    if (casc_oe !== 1'b0) begin errors++; $display("FAIL master_release: got %b want 0", casc_oe); end
  endtask

  task automatic test_slave();
    for (int m = 0; m < 2; m++) begin
      do_reset();
      SNGL = 1'b0; SP = 1'b0; slaveReg = 3'd5; casc_in = (m == 1) ? 3'd5 : 3'd2;
      irr = 8'h01; tick();
      inta_n = 1'b0; tick();
      checks++;
      if (isr !== 8'h01) begin errors++; $display("FAIL slave_isr[%0d]: got %h want 01", m, isr); end
      casc_in = 3'd0;
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++;
      if (data_oe !== 1'(m) || casc_oe !== 1'b0) begin
        errors++; $display("FAIL slave_oe[%0d]: got data_oe=%b casc_oe=%b want %0d/0", m, data_oe, casc_oe, m);
      end
      inta_n = 1'b1; irr = 8'd0; tick();
    end
  endtask

  task automatic test_eoi();
    do_reset();
    run_seq(8'h02);
    irr = 8'h04; tick(); tick();
    checks++;
    if (int_out !== 1'b0 || isr !== 8'h02) begin
      errors++; $display("FAIL eoi_blocked: got int=%b isr=%h want 0/02", int_out, isr);
    end
    eoi = 1'b1; tick();
    eoi = 1'b0;
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL eoi_clear: got %h want 00", isr); end
    tick();
    checks++;
    if (int_out !== 1'b1) begin errors++; $display("FAIL eoi_unblock: got %b want 1", int_out); end
    aeoi = 1'b1;
    inta_n = 1'b0; tick();
    checks++;
    if (isr !== 8'h04) begin errors++; $display("FAIL aeoi_set: got %h want 04", isr); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; irr = 8'd0; tick();
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %h want 00", isr); end
  endtask

  task automatic test_eoi_same_cycle();
    do_reset();
    run_seq(8'h02);
    irr = 8'h01; tick();
    inta_n = 1'b0; eoi = 1'b1; tick();
    eoi = 1'b0;
    checks++;
    if (isr !== 8'h01) begin errors++; $display("FAIL eoi_same_cycle: got %h want 01", isr); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; irr = 8'd0; tick();
  endtask

  task automatic test_timeout();
    do_reset();
    SNGL = 1'b0; SP = 1'b1; slave_map = 8'h08; irr = 8'h08; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    irr = 8'd0;
    repeat (13) tick();
    checks++;
    if (casc_oe !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b want 1", casc_oe); end
    repeat (4) tick();
    checks++;
    if (casc_oe !== 1'b0 || isr !== 8'h08 || data_oe !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: got casc_oe=%b isr=%h data_oe=%b want 0/08/0", casc_oe, isr, data_oe);
    end
    // A late second INTA lands in IDLE and must do nothing.
    inta_n = 1'b0; tick(); tick();
    checks++;
    if (data_oe !== 1'b0 || isr !== 8'h08) begin
      errors++; $display("FAIL idle_inta: got data_oe=%b isr=%h want 0/08", data_oe, isr);
    end
    inta_n = 1'b1; tick();
    // Spurious: request withdrawn before the first INTA.
    do_reset();
    vec_base = 5'h1F; irr = 8'h01; tick();
    irr = 8'd0; tick();
    checks++;
    if (int_out !== 1'b1) begin errors++; $display("FAIL spur_int_hold: got %b want 1", int_out); end
    inta_n = 1'b0; tick();
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", isr); end
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    checks++;
    if (data_out !== 8'hFF || data_oe !== 1'b1) begin
      errors++; $display("FAIL spur_vec: got %h/%b want FF/1", data_out, data_oe);
    end
    inta_n = 1'b1; tick();
  endtask

  task automatic test_reset_ack2();
    do_reset();
    vec_base = 5'h03; irr = 8'h10; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; inta_n = 1'b1; irr = 8'd0;
    checks++;
    if ({int_out, casc_oe, data_oe, casc_out, isr, data_out} !== 22'd0) begin
      errors++; $display("FAIL reset_ack2: got %h want 0", {int_out, casc_oe, data_oe, casc_out, isr, data_out});
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] m_isr, pv, smap;
    logic [4:0] vb;
    logic [2:0] sreg, cin;
    int p, q, mode;
    logic exp_oe, exp_casc, a;
    do_reset();
    m_isr = 8'd0;
    for (int it = 0; it < 60; it++) begin
      mode = $urandom_range(0, 2);
      SNGL = (mode == 0); SP = (mode == 1) ? 1'b1 : ((mode == 2) ? 1'b0 : 1'($urandom));
      irr = 8'($urandom); imr = 8'($urandom) & 8'($urandom);
      if ((irr & ~imr) == 8'd0) begin imr = 8'd0; irr = irr | (8'b1 << $urandom_range(0, 7)); end
      pv = irr & ~imr;
      vb = 5'($urandom); smap = 8'($urandom); sreg = 3'($urandom);
      cin = $urandom_range(0, 1) ? sreg : 3'($urandom);
      a = 1'($urandom);
      vec_base = vb; slave_map = smap; slaveReg = sreg; casc_in = cin; aeoi = a;
      p = lowest(pv); q = lowest(m_isr);
      tick();
      if (p < q) begin
        checks++;
        if (int_out !== 1'b1) begin errors++; $display("FAIL rnd_int[%0d]: got %b want 1", it, int_out); end
        inta_n = 1'b0; tick();
        m_isr[p] = 1'b1;
        exp_casc = (mode == 1) && smap[p];
        exp_oe = (mode == 0) || (mode == 1 && !smap[p]) || (mode == 2 && cin == sreg);
        checks++;
        if (isr !== m_isr) begin errors++; $display("FAIL rnd_isr_set[%0d]: got %h want %h", it, isr, m_isr); end
        checks++;
        if (casc_oe !== exp_casc || (exp_casc && casc_out !== 3'(p))) begin
          errors++; $display("FAIL rnd_casc[%0d]: got %b/%0d want %b/%0d", it, casc_oe, casc_out, exp_casc, p);
        end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_oe !== exp_oe || data_out !== {vb, 3'(p)}) begin
          errors++; $display("FAIL rnd_vec[%0d]: got %h/%b want %h/%b", it, data_out, data_oe, {vb, 3'(p)}, exp_oe);
        end
        inta_n = 1'b1; irr = 8'd0; tick();
        if (a) m_isr[p] = 1'b0;
        checks++;
        if (isr !== m_isr || data_oe !== 1'b0 || casc_oe !== 1'b0) begin
          errors++; $display("FAIL rnd_end[%0d]: got isr=%h oe=%b%b want %h/00", it, isr, data_oe, casc_oe, m_isr);
        end
      end else begin
        checks++;
        if (int_out !== 1'b0) begin errors++; $display("FAIL rnd_blocked[%0d]: got %b want 0", it, int_out); end
        irr = 8'd0; eoi = 1'b1; tick();
        eoi = 1'b0;
        m_isr[q] = 1'b0;
        checks++;
        if (isr !== m_isr) begin errors++; $display("FAIL rnd_eoi[%0d]: got %h want %h", it, isr, m_isr); end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_master();
    test_slave();
    test_eoi();
    test_eoi_same_cycle();
    test_timeout();
    test_reset_ack2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
